// File: rtl/controlador_pin.sv
// PIN entry controller for a card reader: collects 4 BCD digits, verifies them
// against the stored PIN, and grants access, ejects the card or retains it.
module controlador_pin #(
    parameter int unsigned TIMEOUT  = 1000,
    parameter int unsigned MAX_TENT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cartao,
    input  logic        digito_valido,
    input  logic [3:0]  digito,
    input  logic        confirma,
    input  logic        cancela,
    input  logic [15:0] pin_ref,
    output logic        acesso,
    output logic        ejeta,
    output logic        retem,
    output logic        erro,
    output logic [1:0]  tentativas,
    output logic [2:0]  digitos
);

    typedef enum logic [2:0] {
        ESPERA,
        ENTRADA,
        VERIFICA,
        ACESSO,
        EJETA,
        RETEM
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [2:0]  TENT_MAX   = 3'(MAX_TENT);

    state_t      state, state_next;
    logic [15:0] buffer, buffer_next;
    logic [15:0] timer, timer_next;
    logic [2:0]  digitos_next;
    logic [1:0]  tentativas_next;
    logic [2:0]  tent_inc;
    logic        erro_next;
    logic        digit_ok;

    assign digit_ok = digito_valido && (digito <= 4'd9) && (digitos < 3'd4);
    assign tent_inc = {1'b0, tentativas} + 3'd1;

    always_comb begin
        state_next      = state;
        buffer_next     = buffer;
        timer_next      = timer;
        digitos_next    = digitos;
        tentativas_next = tentativas;
        erro_next       = 1'b0;

        case (state)
            ESPERA: begin
                if (cartao) begin
                    state_next      = ENTRADA;
                    buffer_next     = '0;
                    timer_next      = '0;
                    digitos_next    = '0;
                    tentativas_next = '0;
                end
            end
            ENTRADA: begin
                timer_next = timer + 16'd1;
                // Priority: card removed > cancel > timeout > confirm > digit.
                if (!cartao) begin
                    state_next   = ESPERA;
                    buffer_next  = '0;
                    timer_next   = '0;
                    digitos_next = '0;
                end else if (cancela || (timer == TIMER_LAST)) begin
                    state_next   = EJETA;
                    buffer_next  = '0;
                    timer_next   = '0;
                    digitos_next = '0;
                end else if (confirma && (digitos == 3'd4)) begin
                    state_next = VERIFICA;
                end else if (digit_ok) begin
                    buffer_next  = {buffer[11:0], digito};
                    digitos_next = digitos + 3'd1;
                    timer_next   = '0;
                end
            end
            VERIFICA: begin
                if (buffer == pin_ref) begin
                    state_next = ACESSO;
                end else begin
                    erro_next       = 1'b1;
                    tentativas_next = (tent_inc <= TENT_MAX) ? tent_inc[1:0] : tentativas;
                    buffer_next     = '0;
                    timer_next      = '0;
                    digitos_next    = '0;
                    state_next      = (tent_inc >= TENT_MAX) ? RETEM : ENTRADA;
                end
            end
            ACESSO: begin
                if (!cartao) begin
                    state_next   = ESPERA;
                    buffer_next  = '0;
                    digitos_next = '0;
                end else if (cancela) begin
                    state_next   = EJETA;
                    buffer_next  = '0;
                    digitos_next = '0;
                end
            end
            EJETA: begin
                if (!cartao) begin
                    state_next = ESPERA;
                end
            end
            RETEM: begin
                state_next = RETEM;
            end
            default: begin
                state_next = ESPERA;
            end
        endcase
    end

    // Level outputs are decoded from the next state so they track the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ESPERA;
            buffer     <= '0;
            timer      <= '0;
            digitos    <= '0;
            tentativas <= '0;
            erro       <= 1'b0;
            acesso     <= 1'b0;
            ejeta      <= 1'b0;
            retem      <= 1'b0;
        end else begin
            state      <= state_next;
            buffer     <= buffer_next;
            timer      <= timer_next;
            digitos    <= digitos_next;
            tentativas <= tentativas_next;
            erro       <= erro_next;
            acesso     <= (state_next == ACESSO);
            ejeta      <= (state_next == EJETA);
            retem      <= (state_next == RETEM);
        end
    end

endmodule
